// File: rtl/frogger_ps2_pkg.sv
// Shared PS/2 definitions: frame FSM states, scan-code constants and a parity helper.
// Imported by the key decoder and by the downstream keyboard-to-motion mapper.
package frogger_ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  // PS/2 uses odd parity over data plus parity bit
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Key-decoder output bus.
//   key_code  : scan code of the held key, 0x00 when none
//   key_down  : key_code != 0
//   byte_out  : last correctly framed byte
//   byte_tick : one-cycle pulse when byte_out updates
//   frame_err : one-cycle pulse on parity/stop/timeout error
// master = decoder side (drives), slave = consumer side.
interface ps2_key_decoder_if;
  logic [7:0] key_code;
  logic       key_down;
  logic [7:0] byte_out;
  logic       byte_tick;
  logic       frame_err;

  modport master (output key_code, key_down, byte_out, byte_tick, frame_err);
  modport slave  (input  key_code, key_down, byte_out, byte_tick, frame_err);
endinterface

// File: rtl/ps2_edge_filter.sv
// PS/2 input conditioning: 2-FF synchronizers on clock and data, a glitch filter
// on the clock and a registered falling-edge pulse of the filtered clock.
//   clk, rst_n : system clock, synchronous active-low reset
//   ps2c, ps2d : raw asynchronous PS/2 pins (idle high)
//   ps2d_sync  : synchronized data
//   fall_tick  : one-cycle pulse, 2 + FILTER_LEN + 1 cycles after a ps2c fall
module ps2_edge_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c,
  input  logic ps2d,
  output logic ps2d_sync,
  output logic fall_tick
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    c_sync;
  logic [1:0]    d_sync;
  logic          c_filt;
  logic          c_filt_d;
  logic [CW-1:0] cnt;

  // Synchronizers, filter and edge pulse; everything presets to idle high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_sync    <= 2'b11;
      d_sync    <= 2'b11;
      c_filt    <= 1'b1;
      c_filt_d  <= 1'b1;
      cnt       <= '0;
      fall_tick <= 1'b0;
    end else begin
      c_sync   <= {c_sync[0], ps2c};
      d_sync   <= {d_sync[0], ps2d};
      // cnt counts consecutive samples that disagree with the filtered level
      if (c_sync[1] == c_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        c_filt <= c_sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      c_filt_d  <= c_filt;
      fall_tick <= c_filt_d & ~c_filt;
    end
  end

  assign ps2d_sync = d_sync[1];

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: deframes 11-bit frames into bytes and tracks
// make/break/extended sequences to present the currently held key.
//   clk, rst_n : system clock, synchronous active-low reset
//   ps2c, ps2d : raw PS/2 clock/data (asynchronous, idle high)
//   rx_en      : receive enable; low holds the frame FSM in IDLE
//   kb         : output bus (key_code, key_down, byte_out, byte_tick, frame_err)
module ps2_key_decoder
  import frogger_ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 10000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ps2c,
  input  logic                  ps2d,
  input  logic                  rx_en,
  ps2_key_decoder_if.master     kb
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic ps2d_s;
  logic fall;

  ps2_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .ps2d_sync (ps2d_s),
    .fall_tick (fall)
  );

  ps2_state_e    state, state_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic          par, par_n;
  logic [TW-1:0] tmo, tmo_n;
  logic          brk, brk_n;
  logic          ext, ext_n;
  logic [7:0]    key_code, key_code_n;
  logic          key_down, key_down_n;
  logic [7:0]    byte_out, byte_out_n;
  logic          byte_tick, byte_tick_n;
  logic          frame_err, frame_err_n;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift     <= '0;
      bit_cnt   <= '0;
      par       <= 1'b0;
      tmo       <= '0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      key_code  <= '0;
      key_down  <= 1'b0;
      byte_out  <= '0;
      byte_tick <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      shift     <= shift_n;
      bit_cnt   <= bit_cnt_n;
      par       <= par_n;
      tmo       <= tmo_n;
      brk       <= brk_n;
      ext       <= ext_n;
      key_code  <= key_code_n;
      key_down  <= key_down_n;
      byte_out  <= byte_out_n;
      byte_tick <= byte_tick_n;
      frame_err <= frame_err_n;
    end
  end

  // Frame FSM, timeout and byte layer
  always_comb begin
    state_n     = state;
    shift_n     = shift;
    bit_cnt_n   = bit_cnt;
    par_n       = par;
    tmo_n       = '0;
    brk_n       = brk;
    ext_n       = ext;
    key_code_n  = key_code;
    byte_out_n  = byte_out;
    byte_tick_n = 1'b0;
    frame_err_n = 1'b0;

    if (!rx_en) begin
      // Silent abort: partial frame dropped, key and prefixes retained
      state_n = ST_IDLE;
    end else begin
      if (state != ST_IDLE && !fall) begin
        tmo_n = tmo + TW'(1);
      end
      if (state != ST_IDLE && !fall && tmo_n == TW'(TIMEOUT_CYCLES)) begin
        state_n     = ST_IDLE;
        tmo_n       = '0;
        frame_err_n = 1'b1;
        brk_n       = 1'b0;
        ext_n       = 1'b0;
      end else if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!ps2d_s) begin
              state_n   = ST_DATA;
              bit_cnt_n = '0;
            end
          end
          ST_DATA: begin
            shift_n   = {ps2d_s, shift[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_n = ST_PARITY;
          end
          ST_PARITY: begin
            par_n   = ps2d_s;
            state_n = ST_STOP;
          end
          ST_STOP: begin
            state_n = ST_IDLE;
            if (parity_ok(shift, par) && ps2d_s) begin
              byte_tick_n = 1'b1;
              byte_out_n  = shift;
              if (shift == SC_BREAK) begin
                brk_n = 1'b1;
              end else if (shift == SC_EXT) begin
                ext_n = 1'b1;
              end else begin
                // Extended codes never touch key_code
                if (!ext) begin
                  if (!brk)                  key_code_n = shift;
                  else if (shift == key_code) key_code_n = 8'h00;
                end
                brk_n = 1'b0;
                ext_n = 1'b0;
              end
            end else begin
              frame_err_n = 1'b1;
              brk_n       = 1'b0;
              ext_n       = 1'b0;
            end
          end
          default: state_n = ST_IDLE;
        endcase
      end
    end

    key_down_n = (key_code_n != 8'h00);
  end

  assign kb.key_code  = key_code;
  assign kb.key_down  = key_down;
  assign kb.byte_out  = byte_out;
  assign kb.byte_tick = byte_tick;
  assign kb.frame_err = frame_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized scoreboard bench for ps2_key_decoder: the stimulus side pushes the
// expected event for each frame, the monitor pops and compares on every
// byte_tick / frame_err.
module tb_ps2_key_decoder;
  import frogger_ps2_pkg::*;

  localparam int unsigned TMO  = 400;
  localparam int unsigned HALF = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ps2c  = 1'b1;
  logic ps2d  = 1'b1;
  logic rx_en = 1'b1;

  ps2_key_decoder_if kb();

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ps2c  (ps2c),
    .ps2d  (ps2d),
    .rx_en (rx_en),
    .kb    (kb)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] byte_v;
    logic [7:0] key;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: held key, pending prefixes, last good byte
  logic [7:0] m_key  = 8'h00;
  logic [7:0] m_last = 8'h00;
  bit         m_brk  = 1'b0;
  bit         m_ext  = 1'b0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    exp_t e;
    if (!good) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      m_last = b;
      if (b == SC_BREAK) m_brk = 1'b1;
      else if (b == SC_EXT) m_ext = 1'b1;
      else begin
        if (!m_ext && !m_brk) m_key = b;
        else if (!m_ext && m_brk && b == m_key) m_key = 8'h00;
        m_brk = 1'b0;
        m_ext = 1'b0;
      end
    end
    e.err    = !good;
    e.byte_v = m_last;
    e.key    = m_key;
    q.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bit(input bit b);
    ps2d = b;
    wait_clk(HALF);
    ps2c = 1'b0;
    wait_clk(HALF);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop);
    model_byte(b, !flip_par && stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_par);
    send_bit(stop);
    ps2d = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic send_partial(input int n);
    send_bit(1'b0);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    ps2d = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check8({tag, "_key_code"},  kb.key_code, 8'h00);
    check8({tag, "_key_down"},  {7'd0, kb.key_down}, 8'h00);
    check8({tag, "_byte_out"},  kb.byte_out, 8'h00);
    check8({tag, "_byte_tick"}, {7'd0, kb.byte_tick}, 8'h00);
    check8({tag, "_frame_err"}, {7'd0, kb.frame_err}, 8'h00);
  endtask

  // Monitor: every output event must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (kb.byte_tick || kb.frame_err)) begin
        if (kb.byte_tick && kb.frame_err) begin
          total++;
          bad++;
          $display("FAIL tick_err_overlap: both asserted at %0t", $time);
        end
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: tick=%0b err=%0b byte_out=%h key=%h",
                   kb.byte_tick, kb.frame_err, kb.byte_out, kb.key_code);
        end else begin
          e = q.pop_front();
          check8("event_is_err", {7'd0, kb.frame_err}, {7'd0, e.err});
          check8("byte_out", kb.byte_out, e.byte_v);
          check8("key_code", kb.key_code, e.key);
          check8("key_down", {7'd0, kb.key_down}, {7'd0, e.key != 8'h00});
        end
      end
    end
  end

  initial begin
    logic [7:0] tbl [6];
    logic [7:0] b;
    int         r;
    tbl = '{SC_BREAK, SC_EXT, SC_W, SC_A, SC_S, SC_D};

    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(5);
    @(negedge clk);
    check_idle_outputs("reset");

    // Make, then break of the held key
    send_frame(SC_W, 1'b0, 1'b1);
    send_frame(SC_BREAK, 1'b0, 1'b1);
    send_frame(SC_W, 1'b0, 1'b1);

    // Bad parity and bad stop bit
    send_frame(SC_A, 1'b1, 1'b1);
    send_frame(SC_A, 1'b0, 1'b0);

    // Break of another key and extended sequences leave the held key alone
    send_frame(SC_A, 1'b0, 1'b1);
    send_frame(SC_BREAK, 1'b0, 1'b1);
    send_frame(SC_D, 1'b0, 1'b1);
    send_frame(SC_EXT, 1'b0, 1'b1);
    send_frame(SC_W, 1'b0, 1'b1);
    send_frame(SC_EXT, 1'b0, 1'b1);
    send_frame(SC_BREAK, 1'b0, 1'b1);
    send_frame(SC_A, 1'b0, 1'b1);
    send_frame(SC_A, 1'b0, 1'b1);  // typematic repeat

    // Timeout mid-frame, then recovery
    model_byte(8'h00, 1'b0);
    send_partial(3);
    wait_clk(TMO + 40);
    send_frame(SC_D, 1'b0, 1'b1);

    // Short low glitch on ps2c with data low must not start a frame
    ps2d = 1'b0;
    ps2c = 1'b0;
    wait_clk(3);
    ps2c = 1'b1;
    wait_clk(60);
    ps2d = 1'b1;
    @(negedge clk);
    check8("glitch_key_code", kb.key_code, m_key);
    send_frame(SC_S, 1'b0, 1'b1);

    // rx_en drop mid-frame discards it silently
    send_partial(2);
    rx_en = 1'b0;
    wait_clk(5);
    rx_en = 1'b1;
    wait_clk(TMO + 40);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      b = (r < 6) ? tbl[r] : 8'($urandom);
      r = $urandom_range(0, 9);
      send_frame(b, r == 0, r != 1);
    end

    // Mid-frame reset with a key held
    send_frame(SC_W, 1'b0, 1'b1);
    send_frame(SC_S, 1'b0, 1'b1);
    send_partial(3);
    @(posedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    rst_n  = 1'b1;
    m_key  = 8'h00;
    m_last = 8'h00;
    m_brk  = 1'b0;
    m_ext  = 1'b0;
    wait_clk(TMO + 40);
    send_frame(SC_D, 1'b0, 1'b1);

    // Drain the scoreboard within a bounded wait
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the raw PS/2 keyboard clock/data pair, deframes 11-bit PS/2 frames into scan-code bytes, and tracks make/break sequences. It presents the currently held key as an 8-bit scan code. The block sits directly upstream of the keyboard-to-motion mapper, which consumes `key_code` and maps 0x1D/0x1C/0x1B/0x23 (W/A/S/D) to motion commands. `key_code` = 0x00 means no key is held.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical samples required before the filtered `ps2c` level changes.
- `TIMEOUT_CYCLES`, default 10000: maximum `clk` cycles allowed between falling edges inside a frame (200 µs at 50 MHz).
- `clk`  in  1  system clock; the single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `ps2c`  in  1  PS/2 clock; asynchronous, idle high.
- `ps2d`  in  1  PS/2 data; asynchronous, idle high.
- `rx_en`  in  1  receive enable; when low, the frame FSM is held in IDLE.
- `key_code`  out  8  scan code of the held key; 0x00 when none.
- `key_down`  out  1  level; equals (`key_code` != 0).
- `byte_out`  out  8  last correctly framed byte; holds until the next one.
- `byte_tick`  out  1  one-cycle pulse when `byte_out` updates.
- `frame_err`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- Input path:
  - 2-FF synchronizer on `ps2c` and `ps2d`.
  - `ps2c` glitch filter: the level changes only after `FILTER_LEN` consecutive equal samples.
  - Falling-edge detector on the filtered clock.
  - All sampling of `ps2d` happens on a filtered falling edge.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE → DATA: falling edge with `ps2d`=0 (start bit). A falling edge with `ps2d`=1 is ignored.
  - DATA: shift in 8 bits, LSB first, using a 3-bit counter. After bit 7, go to PARITY.
  - PARITY: latch the bit. Odd parity is required: the ones count of data plus parity is odd. Go to STOP.
  - STOP: sample the stop bit, which must be 1. Then return to IDLE.
    - If parity and stop are both good: `byte_tick` pulses.
    - Otherwise: `frame_err` pulses and the byte is discarded.
- Timeout:
  - A counter resets on every falling edge and runs only outside IDLE.
  - Reaching `TIMEOUT_CYCLES` → `frame_err` pulse, FSM returns to IDLE, partial byte discarded.
- `rx_en` low: FSM forced to IDLE, partial frame discarded, no `frame_err`. `key_code` is retained.
- Byte layer, evaluated on each good byte:
  - 0xF0 → set `brk` flag.
  - 0xE0 → set `ext` flag.
  - Other byte, `ext`=0, `brk`=0 (make): `key_code` ← byte. A typematic repeat of the same code leaves it unchanged.
  - Other byte, `ext`=0, `brk`=1 (break): if byte == `key_code`, `key_code` ← 0x00; otherwise no change.
  - Other byte with `ext`=1: ignored for `key_code`.
  - `brk` and `ext` clear after any non-prefix byte.
- `frame_err` clears `brk` and `ext`.

## Timing
- Reset values:
  - `key_code`=0x00, `key_down`=0, `byte_out`=0x00, `byte_tick`=0, `frame_err`=0.
  - FSM in IDLE; `brk` and `ext` cleared; timeout counter at 0.
  - Synchronizers and filter preset to 1 (idle high).
- Edge latency: a `ps2c` fall is detected 2 + `FILTER_LEN` + 1 cycles after the pin change.
- On the cycle after the stop-bit edge is detected, all of the following happen together: `byte_tick` (or `frame_err`), `byte_out`, `key_code` and `key_down`.
- `byte_tick` and `frame_err` are never asserted in the same cycle.
- Reset mid-frame: all state returns to reset values on the next `clk` edge. The remaining bits of the frame are then treated as a new start search.

## Structure
- Shared package `frogger_ps2_pkg` holds:
  - the FSM state enum;
  - scan-code constants: `SC_BREAK` 0xF0, `SC_EXT` 0xE0, `SC_W` 0x1D, `SC_A` 0x1C, `SC_S` 0x1B, `SC_D` 0x23.
- The mapper imports the same constants.
- One sub-module: `ps2_edge_filter`. It contains the synchronizers, the `ps2c` filter and the falling-edge pulse, and outputs the synced `ps2d` plus a `fall_tick` pulse.

## Test plan
- Frame 0x1D with parity 1 and stop 1 → one `byte_tick`, `byte_out`=0x1D, `key_code`=0x1D, `key_down`=1.
- Hold 0x1D, then send F0, 1D → two `byte_tick` pulses; `key_code`=0x00 after the second; `key_down`=0.
- Frame 0x1C with a wrong parity bit (1) → `frame_err` pulse, no `byte_tick`, `key_code` unchanged.
- Hold 0x1C, then send F0, 23 → `key_code` stays 0x1C. Then send E0, 1D and E0, F0, 1C → `key_code` still 0x1C.
- Start bit plus 3 data bits, then `ps2c` idle for `TIMEOUT_CYCLES`+5 → one `frame_err`. A following frame 0x23 decodes to `key_code`=0x23.
- 3-cycle low glitch on `ps2c` while IDLE with `ps2d`=0 → no state change. Assert `rst_n`=0 mid-frame → all outputs return to 0 on the next cycle.
